// File: rtl/store_buffer_pkg.sv
// Shared widths and the memory-port select encoding for the store buffer slice.
// The datapath top and data_memory pick up AD_WD/DATA_WD from here as well.
package store_buffer_pkg;

    localparam int SB_AD_WD   = 16;
    localparam int SB_DATA_WD = 32;

    typedef enum logic [1:0] {
        PORT_LOAD  = 2'd0,
        PORT_DRAIN = 2'd1,
        PORT_IDLE  = 2'd2
    } port_sel_e;

endpackage

// File: rtl/store_buffer_if.sv
// Datapath-side and data-memory-side signals of the store buffer.
// master = datapath + memory, slave = the store buffer itself.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int AD_WD   = SB_AD_WD,
    parameter int DATA_WD = SB_DATA_WD
);
    logic [AD_WD-1:0]   cpu_address;
    logic               cpu_read;
    logic               cpu_write;
    logic [DATA_WD-1:0] cpu_wdata;
    logic [DATA_WD-1:0] cpu_rdata;
    logic               stall;
    logic [AD_WD-1:0]   mem_address;
    logic               mem_write;
    logic [DATA_WD-1:0] mem_wdata;
    logic [DATA_WD-1:0] mem_rdata;

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_wdata, mem_rdata,
        input  cpu_rdata, stall, mem_address, mem_write, mem_wdata
    );

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_wdata, mem_rdata,
        output cpu_rdata, stall, mem_address, mem_write, mem_wdata
    );

endinterface

// File: rtl/store_fifo.sv
// Circular store queue: entry storage, head/tail/count and per-entry valid bits.
// Every entry is exposed so the parent can forward pending stores to loads.
module store_fifo
    import store_buffer_pkg::*;
#(
    parameter int AD_WD   = SB_AD_WD,
    parameter int DATA_WD = SB_DATA_WD,
    parameter int DEPTH   = 4,
    localparam int PTR_WD = $clog2(DEPTH),
    localparam int CNT_WD = PTR_WD + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enq,
    input  logic [AD_WD-1:0]                enq_addr,
    input  logic [DATA_WD-1:0]              enq_data,
    input  logic                            deq,
    output logic [PTR_WD-1:0]               head,
    output logic [AD_WD-1:0]                head_addr,
    output logic [DATA_WD-1:0]              head_data,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][AD_WD-1:0]     entry_addr,
    output logic [DEPTH-1:0][DATA_WD-1:0]   entry_data,
    output logic [CNT_WD-1:0]               count,
    output logic                            empty,
    output logic                            full
);
    logic [PTR_WD-1:0] head_reg;
    logic [PTR_WD-1:0] tail_reg;
    logic [CNT_WD-1:0] count_reg;
    logic              enq_ok;
    logic              deq_ok;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CNT_WD'(DEPTH));
    // A full queue only takes a store in the same cycle its head leaves.
    assign enq_ok = enq && (!full || deq);
    assign deq_ok = deq && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (deq_ok) head_reg <= head_reg + 1'b1;
            if (enq_ok) tail_reg <= tail_reg + 1'b1;
            case ({enq_ok, deq_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic               valid_reg;
        logic [AD_WD-1:0]   addr_reg;
        logic [DATA_WD-1:0] data_reg;
        logic               wr_here;
        logic               rd_here;

        assign wr_here = enq_ok && (tail_reg == PTR_WD'(gi));
        assign rd_here = deq_ok && (head_reg == PTR_WD'(gi));

        // Set wins over clear: a full queue refills the slot it drains.
        always_ff @(posedge clk) begin
            if (reset)        valid_reg <= 1'b0;
            else if (wr_here) valid_reg <= 1'b1;
            else if (rd_here) valid_reg <= 1'b0;
        end

        always_ff @(posedge clk) begin
            if (wr_here) begin
                addr_reg <= enq_addr;
                data_reg <= enq_data;
            end
        end

        assign entry_valid[gi] = valid_reg;
        assign entry_addr[gi]  = addr_reg;
        assign entry_data[gi]  = data_reg;
    end

    assign head      = head_reg;
    assign head_addr = entry_addr[head_reg];
    assign head_data = entry_data[head_reg];
    assign count     = count_reg;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between datapath and data memory: loads own the memory port,
// stores queue up and drain on load-free cycles, loads forward from the queue.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int AD_WD   = SB_AD_WD,
    parameter int DATA_WD = SB_DATA_WD,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_WD = $clog2(DEPTH);

    logic                          full;
    logic                          enq;
    logic                          deq;
    logic                          stall_w;
    logic [PTR_WD-1:0]             head;
    logic [AD_WD-1:0]              head_addr;
    logic [DATA_WD-1:0]            head_data;
    logic [DEPTH-1:0]              entry_valid;
    logic [DEPTH-1:0][AD_WD-1:0]   entry_addr;
    logic [DEPTH-1:0][DATA_WD-1:0] entry_data;
    logic                          fwd_hit;
    logic [DATA_WD-1:0]            fwd_data;
    logic [PTR_WD-1:0]             idx;
    port_sel_e                     port_sel;

    assign stall_w = bus.cpu_write && full && bus.cpu_read;
    assign enq     = bus.cpu_write && !stall_w;
    assign deq     = !bus.cpu_read && !empty;

    store_fifo #(
        .AD_WD   (AD_WD),
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .enq         (enq),
        .enq_addr    (bus.cpu_address),
        .enq_data    (bus.cpu_wdata),
        .deq         (deq),
        .head        (head),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    // Walk from oldest to youngest so the last match is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_WD'(i);
            if (entry_valid[idx] && (entry_addr[idx] == bus.cpu_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end

    always_comb begin
        port_sel = PORT_IDLE;
        if (bus.cpu_read)  port_sel = PORT_LOAD;
        else if (!empty)   port_sel = PORT_DRAIN;
    end

    assign bus.mem_write   = (port_sel == PORT_DRAIN);
    assign bus.mem_address = (port_sel == PORT_DRAIN) ? head_addr : bus.cpu_address;
    assign bus.mem_wdata   = head_data;
    assign bus.cpu_rdata   = fwd_hit ? fwd_data : bus.mem_rdata;
    assign bus.stall       = stall_w;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked
// against a queue-and-array model of pending stores and memory contents.
module tb_store_buffer;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       empty;
    logic [2:0] count;

    store_buffer_if #(.AD_WD(AW), .DATA_WD(DW)) bus();

    store_buffer #(.AD_WD(AW), .DATA_WD(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .empty (empty),
        .count (count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] tb_mem  [0:255];
    logic [DW-1:0] ref_mem [0:255];
    ent_t q[$];
    ent_t exp_log[$];
    ent_t dut_log[$];
    int   errors = 0;
    int   checks = 0;

    assign bus.mem_rdata = tb_mem[bus.mem_address[7:0]];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            tb_mem[bus.mem_address[7:0]] = bus.mem_wdata;
            dut_log.push_back('{addr: bus.mem_address, data: bus.mem_wdata});
        end
    end

    // Model: stores queue in order, loads see the youngest matching store.
    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == a) return q[i].data;
        return ref_mem[a[7:0]];
    endfunction

    function automatic logic exp_stall();
        return bus.cpu_write && bus.cpu_read && (q.size() == DEPTH);
    endfunction

    task automatic set_in(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        bus.cpu_read    = rd;
        bus.cpu_write   = wr;
        bus.cpu_address = a;
        bus.cpu_wdata   = d;
        #1;
    endtask

    task automatic tick();
        logic st;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            st = exp_stall();
            if (!bus.cpu_read && q.size() > 0) begin
                ref_mem[q[0].addr[7:0]] = q[0].data;
                exp_log.push_back(q[0]);
                void'(q.pop_front());
            end
            if (bus.cpu_write && !st)
                q.push_back('{addr: bus.cpu_address, data: bus.cpu_wdata});
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 16'd5, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 16'd5, 32'd0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.cpu_rdata !== ref_mem[5]) begin errors++; $display("FAIL reset_rdata: got %h want %h", bus.cpu_rdata, ref_mem[5]); end
        $display("test_reset: count=%0d empty=%b rdata=%h", count, empty, bus.cpu_rdata);
    endtask

    task automatic test_single_store();
        set_in(1'b0, 1'b1, 16'd5, 32'hDEADBEEF);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b want 0", bus.stall); end
        tick();
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL store_count: got %0d want 1", count); end
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL store_drain_we: got %b want 1", bus.mem_write); end
        checks++; if (bus.mem_address !== 16'd5) begin errors++; $display("FAIL store_drain_addr: got %h want 0005", bus.mem_address); end
        checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_drain_data: got %h want deadbeef", bus.mem_wdata); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL store_empty_after: got %b want 1", empty); end
        checks++; if (tb_mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem5: got %h want deadbeef", tb_mem[5]); end
        $display("test_single_store: mem[5]=%h empty=%b", tb_mem[5], empty);
    endtask

    task automatic test_forward();
        set_in(1'b0, 1'b1, 16'd7, 32'h11);
        tick();
        set_in(1'b1, 1'b0, 16'd7, 32'd0);
        checks++; if (bus.cpu_rdata !== 32'h11) begin errors++; $display("FAIL fwd_rdata: got %h want 00000011", bus.cpu_rdata); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL fwd_no_drain: got %b want 0", bus.mem_write); end
        checks++; if (tb_mem[7] !== 32'hC0DE0007) begin errors++; $display("FAIL fwd_mem_old: got %h want c0de0007", tb_mem[7]); end
        tick();
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        tick();
        checks++; if (tb_mem[7] !== 32'h11) begin errors++; $display("FAIL fwd_mem_new: got %h want 00000011", tb_mem[7]); end
        $display("test_forward: mem[7]=%h", tb_mem[7]);
    endtask

    task automatic test_same_addr();
        int n;
        set_in(1'b1, 1'b1, 16'd3, 32'hA);
        tick();
        set_in(1'b1, 1'b1, 16'd3, 32'hB);
        checks++; if (bus.cpu_rdata !== 32'hA) begin errors++; $display("FAIL same_rdata_a: got %h want 0000000a", bus.cpu_rdata); end
        tick();
        set_in(1'b1, 1'b0, 16'd3, 32'd0);
        checks++; if (bus.cpu_rdata !== 32'hB) begin errors++; $display("FAIL same_rdata_b: got %h want 0000000b", bus.cpu_rdata); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL same_count: got %0d want 2", count); end
        tick();
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        tick();
        tick();
        n = dut_log.size();
        checks++;
        if (n < 2 || dut_log[n-2].addr !== 16'd3 || dut_log[n-2].data !== 32'hA ||
            dut_log[n-1].addr !== 16'd3 || dut_log[n-1].data !== 32'hB) begin
            errors++; $display("FAIL same_order: got %0d writes, last two not (3,a),(3,b)", n);
        end
        checks++; if (tb_mem[3] !== 32'hB) begin errors++; $display("FAIL same_mem3: got %h want 0000000b", tb_mem[3]); end
        $display("test_same_addr: mem[3]=%h empty=%b", tb_mem[3], empty);
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b1, AW'(16'h10 + i), DW'(32'h100 + i));
            tick();
        end
        set_in(1'b1, 1'b1, 16'h20, 32'h999);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        tick();
        set_in(1'b0, 1'b1, 16'h20, 32'h999);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count_hold: got %0d want 4", count); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL full_accept: got %b want 0", bus.stall); end
        checks++; if (bus.mem_address !== 16'h10) begin errors++; $display("FAIL full_drain_addr: got %h want 0010", bus.mem_address); end
        tick();
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count_swap: got %0d want 4", count); end
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got empty=%b want 1", empty); end
        $display("test_full_stall: drained, mem[20]=%h", tb_mem[8'h20]);
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, AW'(16'h30 + i), DW'(32'h300 + i));
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_count_pre: got %0d want 3", count); end
        reset = 1'b1;
        set_in(1'b1, 1'b0, 16'h30, 32'd0);
        tick();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 16'h30, 32'd0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
        n = dut_log.size();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (dut_log.size() != n) begin errors++; $display("FAIL rmid_no_write: got %0d writes want 0", dut_log.size() - n); end
        set_in(1'b1, 1'b0, 16'h31, 32'd0);
        checks++; if (bus.cpu_rdata !== 32'hC0DE0031) begin errors++; $display("FAIL rmid_rdata: got %h want c0de0031", bus.cpu_rdata); end
        tick();
        $display("test_reset_mid: count=%0d rdata31=%h", count, bus.cpu_rdata);
    endtask

    task automatic test_wrap();
        int n;
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        tick();
        n = dut_log.size();
        set_in(1'b0, 1'b1, 16'h40, 32'h400);
        tick();
        for (int k = 0; k < 6; k++) begin
            set_in(1'b0, 1'b1, AW'(16'h41 + k), DW'(32'h401 + k));
            checks++; if (bus.mem_address !== AW'(16'h40 + k) || bus.mem_write !== 1'b1) begin
                errors++; $display("FAIL wrap_drain_%0d: got we=%b addr=%h want we=1 addr=%h", k, bus.mem_write, bus.mem_address, 16'h40 + k);
            end
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count_%0d: got %0d want 1", k, count); end
        end
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        tick();
        checks++; if (dut_log.size() != n + 7) begin
            errors++; $display("FAIL wrap_nwrites: got %0d want 7", dut_log.size() - n);
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (dut_log[n+k].addr !== AW'(16'h40 + k) || dut_log[n+k].data !== DW'(32'h400 + k)) begin
                    errors++; $display("FAIL wrap_order_%0d: got (%h,%h) want (%h,%h)", k, dut_log[n+k].addr, dut_log[n+k].data, 16'h40 + k, 32'h400 + k);
                end
            end
        end
        $display("test_wrap: %0d writes in order, empty=%b", dut_log.size() - n, empty);
    endtask

    task automatic test_random();
        logic          rd, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            bad;
        for (int c = 0; c < 300; c++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 7));
            d  = $urandom;
            set_in(rd, wr, a, d);
            checks++; if (bus.stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall_%0d: got %b want %b", c, bus.stall, exp_stall()); end
            checks++; if (bus.mem_write !== (!rd && q.size() > 0)) begin errors++; $display("FAIL rnd_we_%0d: got %b", c, bus.mem_write); end
            if (!rd && q.size() > 0) begin
                checks++; if (bus.mem_address !== q[0].addr || bus.mem_wdata !== q[0].data) begin
                    errors++; $display("FAIL rnd_drain_%0d: got (%h,%h) want (%h,%h)", c, bus.mem_address, bus.mem_wdata, q[0].addr, q[0].data);
                end
            end else begin
                checks++; if (bus.mem_address !== a) begin errors++; $display("FAIL rnd_addr_%0d: got %h want %h", c, bus.mem_address, a); end
            end
            if (rd) begin
                checks++; if (bus.cpu_rdata !== exp_rdata(a)) begin errors++; $display("FAIL rnd_rdata_%0d: got %h want %h", c, bus.cpu_rdata, exp_rdata(a)); end
            end
            checks++; if (count !== 3'(q.size()) || empty !== (q.size() == 0)) begin
                errors++; $display("FAIL rnd_count_%0d: got %0d/%b want %0d", c, count, empty, q.size());
            end
            tick();
        end
        set_in(1'b0, 1'b0, 16'd0, 32'd0);
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        tick();
        checks++; if (dut_log.size() != exp_log.size()) begin
            errors++; $display("FAIL rnd_log_size: got %0d want %0d", dut_log.size(), exp_log.size());
        end else begin
            bad = 0;
            foreach (exp_log[i]) if (dut_log[i].addr !== exp_log[i].addr || dut_log[i].data !== exp_log[i].data) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rnd_log_order: got %0d out-of-order writes want 0", bad); end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_mem: got %0d differing words want 0", bad); end
        $display("test_random: %0d memory writes total", dut_log.size());
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'hC0DE0000 + i;
            ref_mem[i] = 32'hC0DE0000 + i;
        end
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_wdata   = '0;
        @(negedge clk);
        test_reset();
        test_single_store();
        test_forward();
        test_same_addr();
        test_full_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter AD_WD, default 16, meaning address width.
REQ-002 The block SHALL have parameter DATA_WD, default 32, meaning data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of store entries (power of two, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cpu_address, input, AD_WD bits: load/store address from the datapath.
REQ-007 The block SHALL have port cpu_read, input, 1 bit: load request this cycle.
REQ-008 The block SHALL have port cpu_write, input, 1 bit: store request this cycle.
REQ-009 The block SHALL have port cpu_wdata, input, DATA_WD bits: store data.
REQ-010 The block SHALL have port cpu_rdata, output, DATA_WD bits: load result, combinational.
REQ-011 The block SHALL have port stall, output, 1 bit: store not accepted this cycle, and the datapath holds.
REQ-012 The block SHALL have port mem_address, output, AD_WD bits: address to data memory.
REQ-013 The block SHALL have port mem_write, output, 1 bit: write enable to data memory.
REQ-014 The block SHALL have port mem_wdata, output, DATA_WD bits: write data to data memory.
REQ-015 The block SHALL have port mem_rdata, input, DATA_WD bits: combinational read data from data memory.
REQ-016 The block SHALL have port empty, output, 1 bit: no pending entries.
REQ-017 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of pending entries.

Function
REQ-018 Entries SHALL be held in a circular FIFO with head/tail pointers that wrap modulo DEPTH, plus a count register.
REQ-019 A store SHALL be enqueued at the rising edge when cpu_write=1 and stall=0.
REQ-020 stall SHALL equal cpu_write AND full AND cpu_read, so a full buffer still accepts a store while it drains.
REQ-021 The memory port SHALL be given to the load: when cpu_read=1, mem_address=cpu_address and mem_write=0.
REQ-022 The buffer SHALL drain when cpu_read=0 and empty=0: mem_address and mem_wdata come from the head entry, mem_write=1, and the head advances at the edge.
REQ-023 When cpu_read=0 and empty=1, mem_write SHALL be 0 and mem_address SHALL equal cpu_address.
REQ-024 A load SHALL return, with zero latency, the data of the youngest valid entry whose address equals cpu_address; otherwise it SHALL return mem_rdata.
REQ-025 Stores to the same address SHALL each be enqueued (no coalescing), and program order of stores SHALL be preserved at memory.
REQ-026 On a simultaneous enqueue and drain, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 When cpu_read=1 and cpu_write=1 and the buffer is not full, the load SHALL be serviced and forwarding SHALL see only entries present before this edge.
REQ-028 When cpu_read=cpu_write=0, there SHALL be no enqueue, and draining SHALL proceed.
REQ-029 count SHALL never exceed DEPTH nor underflow; empty SHALL be asserted exactly when count=0.

Reset
REQ-030 On a rising edge with reset=1, head, tail and count SHALL be set to 0 and all entry valid bits cleared.
REQ-031 Reset SHALL take priority over enqueue and drain in the same cycle.
REQ-032 Pending stores SHALL be discarded on a mid-operation reset.
REQ-033 After reset, empty SHALL be 1, count 0, stall 0, and mem_write 0 (with cpu_read=0); cpu_rdata SHALL equal mem_rdata.
REQ-034 Entry data registers SHALL not be required to reset.

Structure
REQ-035 AD_WD and DATA_WD SHALL be shared with data_memory through one common parameter/define header used by the datapath top.
REQ-036 DEPTH SHALL be local to this block.
REQ-037 One sub-module, store_fifo, SHALL hold the entry storage and the head, tail and count logic, and SHALL expose all entries for forwarding.
REQ-038 The forwarding compare and the port mux SHALL live in store_buffer.

Verification
REQ-039 The bench SHALL cover: reset, then a store of 0xDEADBEEF to address 5 with cpu_read=0 -> count=1 next cycle, then mem_write=1 with address 5 and data 0xDEADBEEF, then empty=1.
REQ-040 The bench SHALL cover: a store of 0x11 to address 7, then a load from address 7 the next cycle (drain blocked) -> cpu_rdata=0x11 while memory at address 7 still holds its old value.
REQ-041 The bench SHALL cover: stores of 0xA then 0xB to address 3 under continuous loads -> a load from address 3 returns 0xB; after loads stop, memory receives 0xA then 0xB and ends at 0xB.
REQ-042 The bench SHALL cover: holding cpu_read=1 while 4 stores fill the buffer, with a 5th store plus load -> stall=1 and count=4; dropping cpu_read -> store accepted, count stays 4.
REQ-043 The bench SHALL cover: 3 pending entries and reset=1 for one cycle -> count=0, empty=1, no subsequent mem_write, and a load from a formerly buffered address returns mem_rdata.
REQ-044 The bench SHALL cover: 6 enqueue/drain pairs to check pointer wrap-around -> memory writes occur in issue order and count stays constant.
